recv_block: RTL and testbench
=============================

# recv_block

Serial receive stage of the lab 4 serial link: samples an asynchronous, idle-high serial line and rebuilds 10-bit frames (start 0, 8 data bits LSB first, stop 1). Sits directly downstream of the transmit block's serial output. Delivers each received byte in parallel with a one-cycle ready pulse to the consumer (display/FIFO logic). Detects and flags bad stop bits as framing errors.

## Interface
- CLKS_PER_BIT, 16, clk cycles per serial bit; must be even and ≥ 4.
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- inbit  input  1  serial line, idle high, asynchronous to clk.
- databyte  output  8  last correctly framed byte; holds until the next good frame.
- char_ready  output  1  one-cycle pulse when databyte has just been updated.
- framing_err  output  1  one-cycle pulse when the stop bit sampled 0.
- busy  output  1  high while a frame is in progress (any state except IDLE).
- count  output  4  data bits captured in the current frame, 0..8.

## Operation
- inbit passes through a 2-flop synchronizer (both flops reset to 1). The FSM sees only the synchronized value `rx`.
- Sample counter `scnt`: width $clog2(CLKS_PER_BIT). Bit counter drives `count`. Shift register is 8 bits.
- IDLE: when rx==0, go to START with scnt=0.
- START: scnt increments each cycle. At scnt==CLKS_PER_BIT/2−1:
  - rx==0: go to DATA with scnt=0 and count=0.
  - rx==1: treat as a glitch and return to IDLE with no output.
- DATA: scnt increments. At scnt==CLKS_PER_BIT−1:
  - shift right with rx inserted at bit 7, so the LSB is received first;
  - scnt=0 and count++;
  - after the 8th capture (count becomes 8), go to STOP.
- STOP: scnt increments. At scnt==CLKS_PER_BIT−1, sample rx:
  - rx==1: databyte ← shift register, char_ready=1 for one cycle.
  - rx==0: framing_err=1 for one cycle; databyte is unchanged.
  - Either way, return to IDLE with count=0.
- Every sample lands at the bit midpoint. The stop decision comes half a bit early, so back-to-back frames with no idle gap are received.
- Reset at any time: at the next edge the FSM goes to IDLE, all outputs take their reset values, the synchronizer goes to 1, and scnt/shift register go to 0.
- char_ready and framing_err are never high together.

## Timing
- Reset values: databyte=8'h00, char_ready=0, framing_err=0, busy=0, count=0.
- Call E0 the first rising edge at which inbit is sampled 0.
  - START is entered at E0+2.
  - Data bit k (k=1..8) is captured at E0+2+CLKS_PER_BIT/2+k·CLKS_PER_BIT.
  - The stop decision is at E0+2+CLKS_PER_BIT/2+9·CLKS_PER_BIT, which is E0+154 for the default.
  - char_ready / framing_err are high in the cycle after that edge.
- busy rises at E0+2 and falls with the stop decision (same cycle as the pulse).
- count updates at each capture edge.
- A start pulse shorter than CLKS_PER_BIT/2 synchronized cycles is rejected. busy is high for exactly CLKS_PER_BIT/2 cycles, then clears.
- While busy, inbit is sampled only at the capture points; edges elsewhere are ignored.

## Structure
- Shared package `serial_pkg`:
  - `rx_state_t` enum: IDLE, START, DATA, STOP;
  - FRAME_DATA_BITS=8;
  - default CLKS_PER_BIT. The transmit side uses the same constants.
- Sub-module `sync2`: 2-flop synchronizer with a reset value parameter (1 here).
- FSM, counters and shift register live in recv_block.

## Test plan
- Reset: hold reset for 3 cycles with inbit=1 → all outputs at reset values. Then idle for 50 cycles → busy stays 0 and no pulses.
- Single frame 0xA5 (LSB first, 16 cycles/bit) → count steps 1..8, databyte=8'hA5, char_ready high for exactly one cycle after E0+154, busy low afterwards.
- Glitch: inbit low for 3 cycles, then high → busy high for 8 cycles then low, count=0, no char_ready/framing_err, databyte unchanged.
- Framing error: receive 0x3C cleanly, then send 0x81 with stop bit 0 → framing_err pulses once, char_ready stays 0, databyte stays 8'h3C.
- Back-to-back: 0x00 then 0xFF with no idle gap → two char_ready pulses 160 cycles apart, databyte 8'h00 then 8'hFF.
- Reset mid-frame: assert reset after the 4th data capture → next cycle busy=0, count=0, databyte=8'h00. A following frame 0x5A → databyte=8'h5A.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared constants and state encoding for the lab 4 serial link (transmit and receive sides).
package serial_pkg;

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } rx_state_t;

   localparam int FRAME_DATA_BITS      = 8;
   localparam int DEFAULT_CLKS_PER_BIT = 16;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for bringing an asynchronous level into the clk domain.
module sync2 #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk) begin
      if (reset) begin
         meta <= RESET_VAL;
         q    <= RESET_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/recv_block.sv
// Serial receive stage: rebuilds start/8-data/stop frames from an idle-high line
// and hands each good byte to the consumer with a one-cycle ready pulse.
module recv_block
   import serial_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       inbit,
   output logic [7:0] databyte,
   output logic       char_ready,
   output logic       framing_err,
   output logic       busy,
   output logic [3:0] count
);

   localparam int            SW      = $clog2(CLKS_PER_BIT);
   localparam logic [SW-1:0] HALF_M1 = SW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [SW-1:0] FULL_M1 = SW'(CLKS_PER_BIT - 1);
   localparam logic [SW-1:0] SONE    = SW'(1);
   localparam logic [3:0]    LAST    = 4'(FRAME_DATA_BITS - 1);

   rx_state_t                    state;
   logic                         rx;
   logic [SW-1:0]                scnt;
   logic [FRAME_DATA_BITS-1:0]   shreg;

   sync2 #(.RESET_VAL(1'b1)) u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (inbit),
      .q     (rx)
   );

   // START waits half a bit so every later sample lands mid-bit; STOP decides
   // half a bit early so a following start edge can be caught without a gap.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         scnt        <= '0;
         count       <= 4'd0;
         shreg       <= '0;
         databyte    <= 8'h00;
         char_ready  <= 1'b0;
         framing_err <= 1'b0;
         busy        <= 1'b0;
      end else begin
         char_ready  <= 1'b0;
         framing_err <= 1'b0;
         case (state)
            IDLE: begin
               if (!rx) begin
                  state <= START;
                  scnt  <= '0;
                  busy  <= 1'b1;
               end
            end
            START: begin
               if (scnt == HALF_M1) begin
                  scnt <= '0;
                  if (!rx) begin
                     state <= DATA;
                     count <= 4'd0;
                  end else begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end
               end else begin
                  scnt <= scnt + SONE;
               end
            end
            DATA: begin
               if (scnt == FULL_M1) begin
                  scnt  <= '0;
                  shreg <= {rx, shreg[FRAME_DATA_BITS-1:1]};
                  count <= count + 4'd1;
                  if (count == LAST) begin
                     state <= STOP;
                  end
               end else begin
                  scnt <= scnt + SONE;
               end
            end
            STOP: begin
               if (scnt == FULL_M1) begin
                  scnt  <= '0;
                  state <= IDLE;
                  busy  <= 1'b0;
                  count <= 4'd0;
                  if (rx) begin
                     databyte   <= shreg;
                     char_ready <= 1'b1;
                  end else begin
                     framing_err <= 1'b1;
                  end
               end else begin
                  scnt <= scnt + SONE;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_recv_block.sv
// Directed testbench for recv_block: per-scenario tasks with hand-computed frame timing.
module tb_recv_block;

   logic       clk = 1'b0;
   logic       reset;
   logic       inbit;
   logic [7:0] databyte;
   logic       char_ready;
   logic       framing_err;
   logic       busy;
   logic [3:0] count;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int both_seen = 0;

   int         rdy_cyc[$];
   logic [7:0] rdy_data[$];
   int         err_cyc[$];
   int         cnt_cyc[$];
   logic [3:0] cnt_val[$];
   int         bsy_cyc[$];
   logic       bsy_val[$];
   logic [3:0] prev_count = 4'd0;
   logic       prev_busy  = 1'b0;

   recv_block dut (
      .clk         (clk),
      .reset       (reset),
      .inbit       (inbit),
      .databyte    (databyte),
      .char_ready  (char_ready),
      .framing_err (framing_err),
      .busy        (busy),
      .count       (count)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Event log sampled mid-cycle; cyc here equals the number of the edge just passed.
   always @(negedge clk) begin
      if (char_ready) begin
         rdy_cyc.push_back(cyc);
         rdy_data.push_back(databyte);
      end
      if (framing_err) err_cyc.push_back(cyc);
      if (char_ready && framing_err) both_seen++;
      if (count !== prev_count) begin
         cnt_cyc.push_back(cyc);
         cnt_val.push_back(count);
      end
      if (busy !== prev_busy) begin
         bsy_cyc.push_back(cyc);
         bsy_val.push_back(busy);
      end
      prev_count = count;
      prev_busy  = busy;
   end

   task automatic clear_logs();
      rdy_cyc.delete();
      rdy_data.delete();
      err_cyc.delete();
      cnt_cyc.delete();
      cnt_val.delete();
      bsy_cyc.delete();
      bsy_val.delete();
   endtask

   // Drives the first ncyc cycles of a frame; e0 is the first edge that samples the start bit.
   task automatic drive_frame(input logic [7:0] d, input logic stopb, input int ncyc, output int e0);
      logic [9:0] fr;
      fr = {stopb, d, 1'b0};
      e0 = 0;
      for (int i = 0; i < ncyc; i++) begin
         @(posedge clk);
         #1;
         if (i == 0) e0 = cyc + 1;
         inbit = fr[i / 16];
      end
   endtask

   task automatic idle_cycles(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         inbit = 1'b1;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      inbit = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks += 5;
      if (databyte !== 8'h00) begin failures++; $display("[TB] FAIL reset_databyte got=%h exp=00", databyte); end
      if (char_ready !== 1'b0) begin failures++; $display("[TB] FAIL reset_char_ready got=%b exp=0", char_ready); end
      if (framing_err !== 1'b0) begin failures++; $display("[TB] FAIL reset_framing_err got=%b exp=0", framing_err); end
      if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
      if (count !== 4'd0) begin failures++; $display("[TB] FAIL reset_count got=%0d exp=0", count); end
      @(posedge clk);
      #1;
      reset = 1'b0;
      clear_logs();
      idle_cycles(50);
      @(negedge clk);
      checks += 3;
      if (rdy_cyc.size() != 0) begin failures++; $display("[TB] FAIL idle_ready pulses=%0d exp=0", rdy_cyc.size()); end
      if (err_cyc.size() != 0) begin failures++; $display("[TB] FAIL idle_err pulses=%0d exp=0", err_cyc.size()); end
      if (bsy_cyc.size() != 0) begin failures++; $display("[TB] FAIL idle_busy changes=%0d exp=0", bsy_cyc.size()); end
   endtask

   task automatic test_single_frame();
      int e0;
      clear_logs();
      drive_frame(8'hA5, 1'b1, 160, e0);
      idle_cycles(20);
      @(negedge clk);
      checks++;
      if (cnt_cyc.size() != 9) begin
         failures++;
         $display("[TB] FAIL single_count_steps got=%0d exp=9", cnt_cyc.size());
      end else begin
         for (int k = 1; k <= 9; k++) begin
            checks += 2;
            if (cnt_cyc[k-1] != e0 + 10 + 16 * k - (k == 9 ? 0 : 0) && k < 9) begin
               failures++;
               $display("[TB] FAIL single_count_edge k=%0d got=%0d exp=%0d", k, cnt_cyc[k-1] - e0, 10 + 16 * k);
            end else if (k == 9 && cnt_cyc[8] != e0 + 154) begin
               failures++;
               $display("[TB] FAIL single_count_clear_edge got=%0d exp=154", cnt_cyc[8] - e0);
            end
            if (cnt_val[k-1] !== ((k == 9) ? 4'd0 : 4'(k))) begin
               failures++;
               $display("[TB] FAIL single_count_value k=%0d got=%0d", k, cnt_val[k-1]);
            end
         end
      end
      checks += 5;
      if (rdy_cyc.size() != 1) begin
         failures++;
         $display("[TB] FAIL single_ready pulses=%0d exp=1", rdy_cyc.size());
      end else if (rdy_cyc[0] != e0 + 154) begin
         failures++;
         $display("[TB] FAIL single_ready_time got=E0+%0d exp=E0+154", rdy_cyc[0] - e0);
      end
      if (databyte !== 8'hA5) begin failures++; $display("[TB] FAIL single_databyte got=%h exp=a5", databyte); end
      if (busy !== 1'b0) begin failures++; $display("[TB] FAIL single_busy_after got=%b exp=0", busy); end
      if (err_cyc.size() != 0) begin failures++; $display("[TB] FAIL single_err pulses=%0d exp=0", err_cyc.size()); end
      if (bsy_cyc.size() != 2 || bsy_cyc[0] != e0 + 2 || bsy_cyc[1] != e0 + 154) begin
         failures++;
         $display("[TB] FAIL single_busy_window changes=%0d exp rise E0+2 fall E0+154", bsy_cyc.size());
      end
   endtask

   task automatic test_glitch();
      int e0;
      clear_logs();
      @(posedge clk);
      #1;
      e0 = cyc + 1;
      inbit = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      inbit = 1'b1;
      idle_cycles(30);
      @(negedge clk);
      checks += 5;
      if (bsy_cyc.size() != 2 || bsy_cyc[0] != e0 + 2 || bsy_cyc[1] != e0 + 10 || bsy_val[0] !== 1'b1) begin
         failures++;
         $display("[TB] FAIL glitch_busy changes=%0d exp rise E0+2 fall E0+10", bsy_cyc.size());
      end
      if (count !== 4'd0) begin failures++; $display("[TB] FAIL glitch_count got=%0d exp=0", count); end
      if (rdy_cyc.size() != 0) begin failures++; $display("[TB] FAIL glitch_ready pulses=%0d exp=0", rdy_cyc.size()); end
      if (err_cyc.size() != 0) begin failures++; $display("[TB] FAIL glitch_err pulses=%0d exp=0", err_cyc.size()); end
      if (databyte !== 8'hA5) begin failures++; $display("[TB] FAIL glitch_databyte got=%h exp=a5", databyte); end
   endtask

   task automatic test_framing_err();
      int e0a;
      int e0b;
      clear_logs();
      drive_frame(8'h3C, 1'b1, 160, e0a);
      drive_frame(8'h81, 1'b0, 160, e0b);
      idle_cycles(40);
      @(negedge clk);
      checks += 4;
      if (rdy_cyc.size() != 1 || rdy_data[0] !== 8'h3C) begin
         failures++;
         $display("[TB] FAIL ferr_ready pulses=%0d exp=1 (byte 3c)", rdy_cyc.size());
      end
      if (err_cyc.size() != 1) begin
         failures++;
         $display("[TB] FAIL ferr_pulses got=%0d exp=1", err_cyc.size());
      end else if (err_cyc[0] != e0b + 154) begin
         failures++;
         $display("[TB] FAIL ferr_time got=E0+%0d exp=E0+154", err_cyc[0] - e0b);
      end
      if (databyte !== 8'h3C) begin failures++; $display("[TB] FAIL ferr_databyte got=%h exp=3c", databyte); end
      if (busy !== 1'b0) begin failures++; $display("[TB] FAIL ferr_busy_after got=%b exp=0", busy); end
   endtask

   task automatic test_back_to_back();
      int e0a;
      int e0b;
      clear_logs();
      drive_frame(8'h00, 1'b1, 160, e0a);
      drive_frame(8'hFF, 1'b1, 160, e0b);
      idle_cycles(20);
      @(negedge clk);
      checks++;
      if (rdy_cyc.size() != 2) begin
         failures++;
         $display("[TB] FAIL b2b_pulses got=%0d exp=2", rdy_cyc.size());
      end else begin
         checks += 4;
         if (rdy_cyc[0] != e0a + 154) begin failures++; $display("[TB] FAIL b2b_first_time got=E0+%0d exp=E0+154", rdy_cyc[0] - e0a); end
         if (rdy_cyc[1] - rdy_cyc[0] != 160) begin failures++; $display("[TB] FAIL b2b_spacing got=%0d exp=160", rdy_cyc[1] - rdy_cyc[0]); end
         if (rdy_data[0] !== 8'h00) begin failures++; $display("[TB] FAIL b2b_byte0 got=%h exp=00", rdy_data[0]); end
         if (rdy_data[1] !== 8'hFF) begin failures++; $display("[TB] FAIL b2b_byte1 got=%h exp=ff", rdy_data[1]); end
      end
      checks++;
      if (err_cyc.size() != 0) begin failures++; $display("[TB] FAIL b2b_err pulses=%0d exp=0", err_cyc.size()); end
   endtask

   task automatic test_reset_mid_frame();
      int e0;
      drive_frame(8'h5A, 1'b1, 75, e0);
      @(posedge clk);
      #1;
      checks++;
      if (count !== 4'd4) begin failures++; $display("[TB] FAIL midrst_count_before got=%0d exp=4", count); end
      reset = 1'b1;
      inbit = 1'b1;
      @(negedge clk);
      @(negedge clk);
      checks += 3;
      if (busy !== 1'b0) begin failures++; $display("[TB] FAIL midrst_busy got=%b exp=0", busy); end
      if (count !== 4'd0) begin failures++; $display("[TB] FAIL midrst_count got=%0d exp=0", count); end
      if (databyte !== 8'h00) begin failures++; $display("[TB] FAIL midrst_databyte got=%h exp=00", databyte); end
      @(posedge clk);
      #1;
      reset = 1'b0;
      idle_cycles(5);
      clear_logs();
      drive_frame(8'h5A, 1'b1, 160, e0);
      idle_cycles(20);
      @(negedge clk);
      checks += 2;
      if (rdy_cyc.size() != 1 || rdy_data[0] !== 8'h5A || rdy_cyc[0] != e0 + 154) begin
         failures++;
         $display("[TB] FAIL midrst_refollow pulses=%0d exp=1 byte 5a at E0+154", rdy_cyc.size());
      end
      if (databyte !== 8'h5A) begin failures++; $display("[TB] FAIL midrst_databyte_after got=%h exp=5a", databyte); end
   endtask

   initial begin
      test_reset();
      test_single_frame();
      test_glitch();
      test_framing_err();
      test_back_to_back();
      test_reset_mid_frame();
      checks++;
      if (both_seen != 0) begin failures++; $display("[TB] FAIL pulse_exclusive overlaps=%0d exp=0", both_seen); end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
